// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package if_pkg;

  typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} if_state_t;

  localparam logic [31:0] PC_INC          = 32'd4;
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/if_flush_cnt.sv
// Loadable down-counter that times the flush window after a fetch redirect.
module if_flush_cnt
  import if_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/if_sequencer.sv
// Fetch sequencer: owns the PC and chooses advance, hold or redirect each cycle.
module if_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        except_i,
  input  logic [31:0] except_pc_i,
  input  logic        eret_i,
  output logic [31:0] pc_o,
  output logic        fetch_en_o,
  output logic        flush_o,
  output logic [31:0] epc_o,
  output logic        exc_active_o,
  output logic        halt_o
);

  import if_pkg::*;

  // The counter holds remaining flush cycles minus one, so its zero flag
  // marks the last flush cycle and the exit needs no extra compare.
  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  if_state_t   state_d, state_q;
  logic [31:0] pc_d, pc_q;
  logic [31:0] epc_d, epc_q;
  logic        exc_active_d, exc_active_q;
  logic        fetch_en_d, fetch_en_q;
  logic        flush_d, flush_q;
  logic        halt_d, halt_q;
  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_zero;

  if_flush_cnt #(
    .WIDTH (3)
  ) u_flush_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (CNT_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    epc_d        = epc_q;
    exc_active_d = exc_active_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;

    unique case (state_q)
      BOOT: state_d = RUN;
      RUN, FLUSH: begin
        if (except_i) begin
          if (exc_active_q) begin
            state_d = HALT;
          end else begin
            epc_d        = except_pc_i;
            exc_active_d = 1'b1;
            pc_d         = EXC_VECTOR;
            state_d      = FLUSH;
            cnt_load     = 1'b1;
          end
        end else if (state_q == FLUSH) begin
          pc_d    = pc_q + PC_INC;
          cnt_dec = 1'b1;
          if (cnt_zero) begin
            state_d = RUN;
          end
        end else if (eret_i) begin
          pc_d         = epc_q;
          exc_active_d = 1'b0;
          state_d      = FLUSH;
          cnt_load     = 1'b1;
        end else if (br_taken_i) begin
          pc_d     = br_target_i & WORD_ALIGN_MASK;
          state_d  = FLUSH;
          cnt_load = 1'b1;
        end else if (!stall_i) begin
          pc_d = pc_q + PC_INC;
        end
      end
      default: ;
    endcase

    fetch_en_d = (state_d == RUN);
    flush_d    = (state_d == FLUSH) || (state_d == HALT);
    halt_d     = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      epc_q        <= '0;
      exc_active_q <= 1'b0;
      fetch_en_q   <= 1'b0;
      flush_q      <= 1'b0;
      halt_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      exc_active_q <= exc_active_d;
      fetch_en_q   <= fetch_en_d;
      flush_q      <= flush_d;
      halt_q       <= halt_d;
    end
  end

  assign pc_o         = pc_q;
  assign epc_o        = epc_q;
  assign exc_active_o = exc_active_q;
  assign fetch_en_o   = fetch_en_q;
  assign flush_o      = flush_q;
  assign halt_o       = halt_q;

endmodule

// File: tb/tb_if_sequencer.sv
// Bench for if_sequencer: directed vector table, flush-length sequence, random run against a model.
module tb_if_sequencer;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'h0000_0080;
  localparam int unsigned FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        except_i;
  logic [31:0] except_pc_i;
  logic        eret_i;
  logic [31:0] pc_o;
  logic        fetch_en_o;
  logic        flush_o;
  logic [31:0] epc_o;
  logic        exc_active_o;
  logic        halt_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  if_sequencer #(
    .RESET_PC     (RESET_PC),
    .EXC_VECTOR   (EXC_VECTOR),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .except_i     (except_i),
    .except_pc_i  (except_pc_i),
    .eret_i       (eret_i),
    .pc_o         (pc_o),
    .fetch_en_o   (fetch_en_o),
    .flush_o      (flush_o),
    .epc_o        (epc_o),
    .exc_active_o (exc_active_o),
    .halt_o       (halt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        exc;
    logic [31:0] xpc;
    logic        eret;
    logic [31:0] pc;
    logic        fe;
    logic        fl;
    logic [31:0] epc;
    logic        ea;
    logic        halt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic s, input logic b, input logic [31:0] bt,
                              input logic x, input logic [31:0] xpc, input logic e,
                              input logic [31:0] pc, input logic fe, input logic fl,
                              input logic [31:0] epc, input logic ea, input logic h);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.bt = bt; v.exc = x; v.xpc = xpc; v.eret = e;
    v.pc = pc; v.fe = fe; v.fl = fl; v.epc = epc; v.ea = ea; v.halt = h;
    vecs.push_back(v);
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] bt,
                       input logic x, input logic [31:0] xpc, input logic e);
    rst = r; stall_i = s; br_taken_i = b; br_target_i = bt;
    except_i = x; except_pc_i = xpc; eret_i = e;
    @(posedge clk);
    #1;
  endtask

  // Reference model: remaining-flush counter and plain PC arithmetic.
  logic [31:0] m_pc, m_epc;
  logic        m_exc, m_halt, m_boot;
  int          m_left;

  function automatic void model_step(input logic r, input logic s, input logic b, input logic [31:0] bt,
                                     input logic x, input logic [31:0] xpc, input logic e);
    bit in_flush;
    if (r) begin
      m_pc = RESET_PC; m_epc = '0; m_exc = 1'b0; m_halt = 1'b0; m_left = 0; m_boot = 1'b1;
    end else if (m_halt) begin
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else begin
      in_flush = (m_left > 0);
      if (x) begin
        if (m_exc) m_halt = 1'b1;
        else begin
          m_epc = xpc; m_exc = 1'b1; m_pc = EXC_VECTOR; m_left = FLUSH_CYCLES;
        end
      end else if (in_flush) begin
        m_pc = m_pc + 32'd4; m_left = m_left - 1;
      end else if (e) begin
        m_pc = m_epc; m_exc = 1'b0; m_left = FLUSH_CYCLES;
      end else if (b) begin
        m_pc = {bt[31:2], 2'b00}; m_left = FLUSH_CYCLES;
      end else if (!s) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endfunction

  initial begin
    logic r, s, b, x, e;
    logic [31:0] bt, xpc;
    int flush_len, fe_low;

    // rst stall br  target        exc xpc          eret | pc            fe fl epc       ea halt
    add(1, 0, 0, 32'h0,          0, 32'h0,  0,   32'h0,          0, 0, 32'h0,  0, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h0,          1, 0, 32'h0,  0, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h4,          1, 0, 32'h0,  0, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h8,          1, 0, 32'h0,  0, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'hC,          1, 0, 32'h0,  0, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h10,         1, 0, 32'h0,  0, 0);
    add(0, 0, 1, 32'h47,         0, 32'h0,  0,   32'h44,         0, 1, 32'h0,  0, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h48,         0, 1, 32'h0,  0, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h4C,         1, 0, 32'h0,  0, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h50,         1, 0, 32'h0,  0, 0);
    add(0, 0, 0, 32'h0,          1, 32'h20, 0,   32'h80,         0, 1, 32'h20, 1, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h84,         0, 1, 32'h20, 1, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h88,         1, 0, 32'h20, 1, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h8C,         1, 0, 32'h20, 1, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  1,   32'h20,         0, 1, 32'h20, 0, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h24,         0, 1, 32'h20, 0, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h28,         1, 0, 32'h20, 0, 0);
    add(0, 0, 1, 32'h100,        1, 32'h28, 0,   32'h80,         0, 1, 32'h28, 1, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h84,         0, 1, 32'h28, 1, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h88,         1, 0, 32'h28, 1, 0);
    add(0, 0, 0, 32'h0,          1, 32'h88, 0,   32'h88,         0, 1, 32'h28, 1, 1);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h88,         0, 1, 32'h28, 1, 1);
    add(0, 0, 1, 32'h200,        0, 32'h0,  1,   32'h88,         0, 1, 32'h28, 1, 1);
    add(1, 0, 0, 32'h0,          0, 32'h0,  0,   32'h0,          0, 0, 32'h0,  0, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h0,          1, 0, 32'h0,  0, 0);
    add(0, 0, 1, 32'h28,         0, 32'h0,  0,   32'h28,         0, 1, 32'h0,  0, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h2C,         0, 1, 32'h0,  0, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h30,         1, 0, 32'h0,  0, 0);
    add(0, 1, 0, 32'h0,          0, 32'h0,  0,   32'h30,         1, 0, 32'h0,  0, 0);
    add(0, 1, 0, 32'h0,          0, 32'h0,  0,   32'h30,         1, 0, 32'h0,  0, 0);
    add(0, 1, 0, 32'h0,          0, 32'h0,  0,   32'h30,         1, 0, 32'h0,  0, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h34,         1, 0, 32'h0,  0, 0);
    add(0, 0, 1, 32'h60,         0, 32'h0,  0,   32'h60,         0, 1, 32'h0,  0, 0);
    add(0, 1, 1, 32'h200,        0, 32'h0,  1,   32'h64,         0, 1, 32'h0,  0, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h68,         1, 0, 32'h0,  0, 0);
    add(0, 0, 1, 32'hFFFF_FFF1,  0, 32'h0,  0,   32'hFFFF_FFF0,  0, 1, 32'h0,  0, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'hFFFF_FFF4,  0, 1, 32'h0,  0, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'hFFFF_FFF8,  1, 0, 32'h0,  0, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'hFFFF_FFFC,  1, 0, 32'h0,  0, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h0,          1, 0, 32'h0,  0, 0);
    add(0, 0, 1, 32'h40,         0, 32'h0,  0,   32'h40,         0, 1, 32'h0,  0, 0);
    add(1, 0, 0, 32'h0,          0, 32'h0,  0,   32'h0,          0, 0, 32'h0,  0, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h0,          1, 0, 32'h0,  0, 0);
    add(0, 0, 1, 32'h10,         0, 32'h0,  0,   32'h10,         0, 1, 32'h0,  0, 0);
    add(0, 0, 0, 32'h0,          1, 32'h14, 0,   32'h80,         0, 1, 32'h14, 1, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h84,         0, 1, 32'h14, 1, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h88,         1, 0, 32'h14, 1, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  1,   32'h14,         0, 1, 32'h14, 0, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h18,         0, 1, 32'h14, 0, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h1C,         1, 0, 32'h14, 0, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  1,   32'h14,         0, 1, 32'h14, 0, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h18,         0, 1, 32'h14, 0, 0);
    add(0, 0, 0, 32'h0,          0, 32'h0,  0,   32'h1C,         1, 0, 32'h14, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].bt, vecs[i].exc, vecs[i].xpc, vecs[i].eret);
      chk($sformatf("vec%0d pc_o", i),         pc_o,                 vecs[i].pc);
      chk($sformatf("vec%0d fetch_en_o", i),   {31'b0, fetch_en_o},  {31'b0, vecs[i].fe});
      chk($sformatf("vec%0d flush_o", i),      {31'b0, flush_o},     {31'b0, vecs[i].fl});
      chk($sformatf("vec%0d epc_o", i),        epc_o,                vecs[i].epc);
      chk($sformatf("vec%0d exc_active_o", i), {31'b0, exc_active_o}, {31'b0, vecs[i].ea});
      chk($sformatf("vec%0d halt_o", i),       {31'b0, halt_o},      {31'b0, vecs[i].halt});
    end

    // Flush window length measured with a bounded wait after one branch.
    drive(0, 0, 1, 32'h300, 0, 32'h0, 0);
    flush_len = 0;
    fe_low    = 0;
    for (int i = 0; i < 16; i++) begin
      if (!flush_o) break;
      flush_len++;
      if (!fetch_en_o) fe_low++;
      drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
    end
    chk("flush_len", 32'(flush_len), 32'(FLUSH_CYCLES));
    chk("fetch_en_low_len", 32'(fe_low), 32'(FLUSH_CYCLES));
    chk("pc_after_flush", pc_o, 32'h300 + 32'(4 * FLUSH_CYCLES));
    chk("fetch_en_after_flush", {31'b0, fetch_en_o}, 32'd1);

    model_step(1, 0, 0, 32'h0, 0, 32'h0, 0);
    drive(1, 0, 0, 32'h0, 0, 32'h0, 0);
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(99) == 0);
      s   = ($urandom_range(3) == 0);
      b   = ($urandom_range(7) == 0);
      x   = ($urandom_range(29) == 0);
      e   = ($urandom_range(19) == 0);
      bt  = $urandom;
      xpc = $urandom;
      model_step(r, s, b, bt, x, xpc, e);
      drive(r, s, b, bt, x, xpc, e);
      chk("rnd pc_o",         pc_o,                  m_pc);
      chk("rnd fetch_en_o",   {31'b0, fetch_en_o},   {31'b0, !m_boot && !m_halt && (m_left == 0)});
      chk("rnd flush_o",      {31'b0, flush_o},      {31'b0, m_halt || (m_left > 0)});
      chk("rnd epc_o",        epc_o,                 m_epc);
      chk("rnd exc_active_o", {31'b0, exc_active_o}, {31'b0, m_exc});
      chk("rnd halt_o",       {31'b0, halt_o},       {31'b0, m_halt});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_sequencer.md
Name: if_sequencer

Overview:
Controls instruction fetch. Owns the program counter and decides each cycle whether to advance, hold or redirect it. Inputs come from the later pipeline stages: stall, branch, exception and exception-return. Drives the PC-register and ROM address path in place of the free-running next-PC mux, and generates the IF/ID flush and fetch-enable qualifiers.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded by reset.
EXC_VECTOR, 32'h0000_0080, handler address loaded on exception.
FLUSH_CYCLES, 2, cycles of flush_o after a redirect; covers ROM read latency plus the IF output register. Legal range 1..7.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
stall_i  in  1  hold PC; load-use hazard from ID
br_taken_i  in  1  taken branch or jump resolved in EX
br_target_i  in  32  branch/jump target
except_i  in  1  exception raised by a later stage
except_pc_i  in  32  address of the faulting instruction
eret_i  in  1  return from exception handler
pc_o  out  32  current fetch address to PC register and ROM
fetch_en_o  out  1  fetched instruction is valid
flush_o  out  1  kill the instruction in IF/ID
epc_o  out  32  saved exception PC
exc_active_o  out  1  handler in progress
halt_o  out  1  double fault; fetch stopped

Behaviour:
- Reset, on any clk edge with rst=1, including mid-flush or mid-handler:
  - pc_o=RESET_PC, fetch_en_o=0, flush_o=0, epc_o=0, exc_active_o=0, halt_o=0, flush counter=0, state=BOOT.
- States: BOOT, RUN, FLUSH, HALT.
- BOOT: lasts one cycle and always goes to RUN. pc_o holds. All inputs are ignored.
- RUN: fetch_en_o=1. Next-PC priority is except_i > eret_i > br_taken_i > stall_i > sequential.
  - except_i with exc_active_o=0:
    - epc_o<=except_pc_i, exc_active_o<=1, pc_o<=EXC_VECTOR.
    - Go to FLUSH.
  - except_i with exc_active_o=1:
    - Go to HALT, halt_o<=1, pc_o holds.
    - epc_o and exc_active_o are unchanged.
  - eret_i:
    - pc_o<=epc_o, exc_active_o<=0.
    - Go to FLUSH. eret_i with exc_active_o=0 is still honoured.
  - br_taken_i: pc_o<={br_target_i[31:2],2'b00}, go to FLUSH.
  - stall_i: pc_o holds, fetch_en_o=1.
  - Otherwise: pc_o<=pc_o+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Redirect timing:
  - Event sampled at edge N gives the new pc_o after edge N.
  - flush_o=1 for exactly FLUSH_CYCLES cycles starting the cycle after edge N.
  - fetch_en_o=0 while flush_o=1.
- FLUSH:
  - pc_o advances +4 each cycle from the redirect target, with no stall hold.
  - The counter decrements each cycle; at 0 the state returns to RUN and flush_o drops.
  - br_taken_i, eret_i and stall_i are ignored, because they originate from killed instructions.
  - except_i is honoured under the same rules as RUN and reloads the counter to FLUSH_CYCLES.
- HALT: fetch_en_o=0, flush_o=1, pc_o frozen. Only rst exits.
- Simultaneous events: only the highest-priority event takes effect in a cycle; lower ones are dropped, not queued.
- flush_o, fetch_en_o and halt_o are registered outputs with no combinational input-to-output paths.

Decomposition:
- Package if_pkg holds:
  - typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} if_state_t;
  - constants PC_INC=32'd4 and WORD_ALIGN_MASK=32'hFFFF_FFFC.
- Sub-module if_flush_cnt: a loadable down-counter with load, value and zero flag.
- Next-PC selection and the state machine stay in if_sequencer.

Test Plan:
- Reset, then 4 idle cycles -> pc_o sequence 0, 0(BOOT), 4, 8, 12; fetch_en_o=0 only during reset and BOOT.
- At pc_o=0x10, br_taken_i=1 with target 0x47 -> pc_o=0x44, 0x48, then 0x4C; flush_o high for exactly 2 cycles; fetch_en_o low for those same 2 cycles.
- Exception at except_pc_i=0x20 -> epc_o=0x20, exc_active_o=1, pc_o=0x80 then 0x84.
  - Later eret_i -> pc_o=0x20, exc_active_o=0, flush_o for 2 cycles.
- except_i and br_taken_i in the same cycle -> pc_o=0x80 and the branch is dropped.
  - A second except_i while exc_active_o=1 -> halt_o=1 and pc_o frozen.
  - rst then clears everything to reset values.
- stall_i held 3 cycles at pc_o=0x30 -> pc_o stays 0x30 for 3 cycles with no flush.
  - br_taken_i during the FLUSH of an earlier branch is ignored.
- Starting from pc_o=0xFFFF_FFF8 -> pc_o=0xFFFF_FFFC then 0x0000_0000.
  - rst asserted mid-flush -> flush_o=0 and pc_o=RESET_PC on the next cycle.
